bus_trace_recorder: RTL

//  Parametrised trace recorder between bus snooper and usart_tx. Stores WIDTH-bit samples in a DEPTH-entry circular buffer.

---
 rtl/bus_trace_pkg.sv | 28 ++
 rtl/trace_ram.sv | 23 ++
 rtl/bus_trace_recorder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_trace_pkg.sv
// rtl/bus_trace_pkg.sv - shared types, ASCII constants and helpers for the bus trace recorder
package bus_trace_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    POSTTRIG,
    CAPTURED,
    DUMP
  } state_t;

  // Symbol index width: covers up to 2*8 hex chars plus CR/LF for 64-bit samples
  localparam int SYM_W = 5;

  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_LF   = 8'h0A;
  localparam logic [7:0] CHAR_DASH = 8'h2D;

  function automatic int bytes_per_sample(input int width);
    return (width + 7) / 8;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] nibble);
    if (nibble < 4'd10) return 8'h30 + {4'h0, nibble};
    else                return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port sample buffer, sync write, registered read
module trace_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the array or read register so the buffer maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bus_trace_recorder.sv
// rtl/bus_trace_recorder.sv - triggered circular trace capture with byte-stream dump; TRACE_HEX_EN selects ASCII hex output
module bus_trace_recorder
  import bus_trace_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     comm_clock,
  input  logic                     reset_n,
  input  logic                     arm,
  input  logic                     force_trigger,
  input  logic [WIDTH-1:0]         trig_value,
  input  logic [WIDTH-1:0]         trig_mask,
  input  logic [$clog2(DEPTH)-1:0] post_count,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     dump_start,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     armed,
  output logic                     captured,
  output logic                     dump_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int B  = bytes_per_sample(WIDTH);
  localparam int PW = 8 * B;
`ifdef TRACE_HEX_EN
  localparam int SYMS = 2 * B + 2;
`else
  localparam int SYMS = B;
`endif
  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

  state_t           state;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    post_len;
  logic             wrapped;
  logic [AW:0]      to_fetch;
  logic             rd_pending;
  logic             cur_valid;
  logic             in_trailer;
  logic [PW-1:0]    cur_sample;
  logic [SYM_W-1:0] sym_idx;
  logic [WIDTH-1:0] rd_data;

  logic             hit;
  logic             store;
  logic             fire;
  logic             last_sym;
  logic             load;
  logic             fetch;
  logic             start;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [AW:0]      dump_len;
  logic [AW-1:0]    dump_first;

  assign hit        = in_valid && (((in_data ^ trig_value) & trig_mask) == '0);
  assign store      = in_valid && !arm && (state == PRETRIG || state == POSTTRIG);
  assign dump_len   = wrapped ? FULL_LEN : {1'b0, wr_ptr};
  assign dump_first = wrapped ? wr_ptr : '0;

  // The RAM output register acts as a one-sample prefetch buffer (rd_pending);
  // a new read is issued whenever that buffer is empty or being consumed.
  assign fire     = cur_valid && out_ready;
  assign last_sym = in_trailer ? (sym_idx == SYM_W'(3)) : (sym_idx == SYM_W'(SYMS - 1));
  assign load     = (state == DUMP) && rd_pending &&
                    (!cur_valid || (fire && last_sym && !in_trailer));
  assign fetch    = (state == DUMP) && (to_fetch != '0) && (!rd_pending || load);
  assign start    = (state == CAPTURED) && dump_start && !arm && (dump_len != '0);
  assign rd_en    = start || fetch;
  assign rd_addr  = start ? dump_first : rd_ptr;

  assign out_valid = cur_valid;
  assign armed     = (state == PRETRIG) || (state == POSTTRIG);
  assign captured  = (state == CAPTURED);

  trace_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (comm_clock),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (in_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Select the current output symbol from the held sample and symbol index
  always_comb begin
    out_data = 8'h00;
`ifdef TRACE_HEX_EN
    if (in_trailer) begin
      if (sym_idx < SYM_W'(2))       out_data = CHAR_DASH;
      else if (sym_idx == SYM_W'(2)) out_data = CHAR_CR;
      else                           out_data = CHAR_LF;
    end else if (sym_idx == SYM_W'(2 * B)) begin
      out_data = CHAR_CR;
    end else if (sym_idx == SYM_W'(2 * B + 1)) begin
      out_data = CHAR_LF;
    end else begin
      for (int i = 0; i < 2 * B; i++) begin
        if (sym_idx == SYM_W'(2 * B - 1 - i)) out_data = hex_char(cur_sample[i*4 +: 4]);
      end
    end
`else
    for (int i = 0; i < B; i++) begin
      if (sym_idx == SYM_W'(B - 1 - i)) out_data = cur_sample[i*8 +: 8];
    end
`endif
  end

  // Capture FSM, write pointer, post-trigger counter and dump serializer
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      wrapped    <= 1'b0;
      cnt        <= '0;
      post_len   <= '0;
      rd_ptr     <= '0;
      to_fetch   <= '0;
      rd_pending <= 1'b0;
      cur_valid  <= 1'b0;
      in_trailer <= 1'b0;
      cur_sample <= '0;
      sym_idx    <= '0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= 1'b0;

      if (store) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (wr_ptr == '1) wrapped <= 1'b1;
      end

      case (state)
        IDLE, PRETRIG, POSTTRIG, CAPTURED: begin
          if (arm) begin
            state    <= PRETRIG;
            wr_ptr   <= '0;
            wrapped  <= 1'b0;
            post_len <= post_count;
          end else if (state == PRETRIG) begin
            if (hit || force_trigger) begin
              if (post_len == '0) begin
                state <= CAPTURED;
              end else begin
                state <= POSTTRIG;
                cnt   <= post_len;
              end
            end
          end else if (state == POSTTRIG) begin
            if (in_valid) begin
              cnt <= cnt - AW'(1);
              if (cnt == AW'(1)) state <= CAPTURED;
            end
          end else if (state == CAPTURED && dump_start) begin
            if (dump_len == '0) begin
              dump_done <= 1'b1;
            end else begin
              state      <= DUMP;
              rd_ptr     <= dump_first + AW'(1);
              to_fetch   <= dump_len - (AW+1)'(1);
              rd_pending <= 1'b1;
              cur_valid  <= 1'b0;
              in_trailer <= 1'b0;
            end
          end
        end

        DUMP: begin
          if (fetch) begin
            rd_ptr   <= rd_ptr + AW'(1);
            to_fetch <= to_fetch - (AW+1)'(1);
          end
          rd_pending <= fetch || (rd_pending && !load);

          if (load) begin
            cur_sample <= PW'(rd_data);
            sym_idx    <= '0;
            cur_valid  <= 1'b1;
          end else if (fire) begin
            if (!last_sym) begin
              sym_idx <= sym_idx + SYM_W'(1);
            end else if (!in_trailer) begin
`ifdef TRACE_HEX_EN
              in_trailer <= 1'b1;
              sym_idx    <= '0;
`else
              cur_valid <= 1'b0;
              dump_done <= 1'b1;
              state     <= CAPTURED;
`endif
            end else begin
              cur_valid  <= 1'b0;
              in_trailer <= 1'b0;
              dump_done  <= 1'b1;
              state      <= CAPTURED;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
